psram_qspi_responder: RTL and testbench



---
 rtl/psram_qspi_responder.sv | 141 ++++++++++++++
 tb/tb_psram_qspi_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/psram_qspi_responder.sv
// psram_qspi_responder: QSPI PSRAM device model (EBh quad read, 38h quad write) oversampled on clk_i, with a byte-wide backdoor port.
module psram_qspi_responder #(
   parameter int ADDR_W       = 12,
   parameter int DUMMY_CYCLES = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sck_i,
   input  logic              ce_n_i,
   input  logic [3:0]        sio_i,
   output logic [3:0]        sio_o,
   output logic [3:0]        sio_oe,
   input  logic              bd_we,
   input  logic [ADDR_W-1:0] bd_addr,
   input  logic [7:0]        bd_wdata,
   output logic [7:0]        bd_rdata,
   output logic              busy,
   output logic              cmd_err
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;
   state_t            state, state_d;
   logic [2:0]        sck_q, ce_q;
   logic [3:0]        sio_s1, sio_s2;
   logic [7:0]        cnt, cnt_d, cmd, cmd_d;
   logic [ADDR_W-1:0] a, a_d;
   logic [3:0]        hi, hi_d, sio_o_d, oe_d;
   logic              rd, rd_d, nib, nib_d, err_d, we;
   logic              rise, fall, ce_rise, ce_fall;
   logic [7:0]        rdata;
   logic [7:0]        mem [2**ADDR_W];
   // sio shares the sck synchronizer depth so sampled data lines up with the detected edge
   assign rise    = sck_q[1] & ~sck_q[2] & ~ce_q[1];
   assign fall    = ~sck_q[1] & sck_q[2] & ~ce_q[1];
   assign ce_rise = ce_q[1] & ~ce_q[2];
   assign ce_fall = ~ce_q[1] & ce_q[2];
   assign busy    = ~ce_q[1];
   assign rdata   = mem[a];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         sck_q    <= 3'b000;
         ce_q     <= 3'b111;
         sio_s1   <= 4'h0;
         sio_s2   <= 4'h0;
         cnt      <= 8'h00;
         cmd      <= 8'h00;
         a        <= '0;
         hi       <= 4'h0;
         rd       <= 1'b0;
         nib      <= 1'b0;
         sio_o    <= 4'h0;
         sio_oe   <= 4'h0;
         cmd_err  <= 1'b0;
         bd_rdata <= 8'h00;
      end else begin
         state    <= state_d;
         sck_q    <= {sck_q[1:0], sck_i};
         ce_q     <= {ce_q[1:0], ce_n_i};
         sio_s1   <= sio_i;
         sio_s2   <= sio_s1;
         cnt      <= cnt_d;
         cmd      <= cmd_d;
         a        <= a_d;
         hi       <= hi_d;
         rd       <= rd_d;
         nib      <= nib_d;
         sio_o    <= sio_o_d;
         sio_oe   <= oe_d;
         cmd_err  <= err_d;
         bd_rdata <= mem[bd_addr];
      end
   end
   // QSPI write is assigned last so it wins a same-address collision with the backdoor
   always_ff @(posedge clk_i) begin
      if (bd_we) mem[bd_addr] <= bd_wdata;
      if (we) mem[a] <= {hi, sio_s2};
   end
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      cmd_d   = cmd;
      a_d     = a;
      hi_d    = hi;
      rd_d    = rd;
      nib_d   = nib;
      sio_o_d = sio_o;
      oe_d    = sio_oe;
      err_d   = 1'b0;
      we      = 1'b0;
      if (ce_rise) begin
         state_d = IDLE;
         oe_d    = 4'h0;
      end else begin
         case (state)
            IDLE: if (ce_fall) begin
               state_d = CMD;
               cnt_d   = 8'h00;
            end
            CMD: if (rise) begin
               cmd_d = {cmd[6:0], sio_s2[0]};
               cnt_d = cnt + 8'h01;
               if (cnt == 8'd7) begin
                  cnt_d   = 8'h00;
                  rd_d    = cmd_d == 8'hEB;
                  state_d = (cmd_d == 8'hEB || cmd_d == 8'h38) ? ADDR : IGNORE;
                  err_d   = !(cmd_d == 8'hEB || cmd_d == 8'h38);
               end
            end
            ADDR: if (rise) begin
               a_d   = {a[ADDR_W-5:0], sio_s2};
               cnt_d = cnt + 8'h01;
               if (cnt == 8'd5) begin
                  cnt_d   = 8'h00;
                  nib_d   = 1'b0;
                  state_d = rd ? ((DUMMY_CYCLES == 0) ? RDATA : DUMMY) : WDATA;
               end
            end
            DUMMY: if (rise) begin
               cnt_d = cnt + 8'h01;
               if (cnt == 8'(DUMMY_CYCLES - 1)) begin
                  cnt_d   = 8'h00;
                  state_d = RDATA;
               end
            end
            RDATA: if (fall) begin
               oe_d    = 4'hF;
               sio_o_d = nib ? rdata[3:0] : rdata[7:4];
               nib_d   = ~nib;
               a_d     = nib ? a + 1'b1 : a;
            end
            WDATA: if (rise) begin
               hi_d  = nib ? hi : sio_s2;
               we    = nib;
               nib_d = ~nib;
               a_d   = nib ? a + 1'b1 : a;
            end
            default: oe_d = 4'h0;
         endcase
      end
   end
endmodule

// File: tb/tb_psram_qspi_responder.sv
// tb_psram_qspi_responder: directed and randomized QSPI transactions checked against a byte-array reference model.
module tb_psram_qspi_responder;
   localparam int AW = 12;
   localparam int DC = 6;
   localparam int HP = 40;
   logic          clk_i = 1'b0, rst_i = 1'b1, sck_i = 1'b0, ce_n_i = 1'b1, bd_we = 1'b0;
   logic [3:0]    sio_i = 4'h0, sio_o, sio_oe;
   logic [AW-1:0] bd_addr = '0;
   logic [7:0]    bd_wdata = 8'h00, bd_rdata;
   logic          busy, cmd_err;
   logic [7:0]    ref_mem [2**AW];
   int            n_chk = 0, n_fail = 0, err_pulses = 0;
   always #5 clk_i = ~clk_i;
   always @(negedge clk_i) if (cmd_err) err_pulses++;
   psram_qspi_responder #(.ADDR_W(AW), .DUMMY_CYCLES(DC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .sck_i(sck_i), .ce_n_i(ce_n_i), .sio_i(sio_i),
      .sio_o(sio_o), .sio_oe(sio_oe), .bd_we(bd_we), .bd_addr(bd_addr),
      .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .busy(busy), .cmd_err(cmd_err)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
      sck_i = 1'b0;
      sio_i = d;
      #HP;
      q  = sio_o;
      oe = sio_oe;
      sck_i = 1'b1;
      #HP;
   endtask
   task automatic begin_txn();
      sck_i  = 1'b0;
      ce_n_i = 1'b0;
      #HP;
   endtask
   task automatic end_txn();
      sck_i = 1'b0;
      #HP;
      ce_n_i = 1'b1;
      #(2*HP);
   endtask
   task automatic send_hdr(input logic [7:0] op, input logic [23:0] ad, input string tag);
      logic [3:0] q, oe;
      for (int i = 0; i < 8; i++) begin
         cyc({3'b000, op[7-i]}, q, oe);
         chk({tag, " cmd oe"}, 32'(oe), 0);
      end
      for (int i = 0; i < 6; i++) begin
         cyc(ad[23-4*i -: 4], q, oe);
         chk({tag, " addr oe"}, 32'(oe), 0);
      end
   endtask
   task automatic qread(input logic [23:0] ad, input int nb, input string tag);
      logic [3:0]    q, oe;
      logic [AW-1:0] a;
      begin_txn();
      send_hdr(8'hEB, ad, tag);
      chk({tag, " busy"}, 32'(busy), 1);
      for (int i = 0; i < DC; i++) begin
         cyc(4'($urandom), q, oe);
         chk({tag, " dummy oe"}, 32'(oe), 0);
      end
      for (int i = 0; i < nb; i++) begin
         a = ad[AW-1:0] + AW'(i);
         cyc(4'h0, q, oe);
         chk({tag, " hi"}, 32'(q), 32'(ref_mem[a][7:4]));
         chk({tag, " data oe"}, 32'(oe), 32'hF);
         cyc(4'h0, q, oe);
         chk({tag, " lo"}, 32'(q), 32'(ref_mem[a][3:0]));
      end
      end_txn();
      chk({tag, " oe after"}, 32'(sio_oe), 0);
      chk({tag, " busy after"}, 32'(busy), 0);
   endtask
   task automatic qwrite(input logic [23:0] ad, input logic [63:0] nv, input int nn, input string tag);
      logic [3:0] q, oe;
      begin_txn();
      send_hdr(8'h38, ad, tag);
      for (int i = 0; i < nn; i++) begin
         cyc(nv[4*(nn-1-i) +: 4], q, oe);
         chk({tag, " wdata oe"}, 32'(oe), 0);
      end
      end_txn();
      for (int k = 0; k < nn / 2; k++)
         ref_mem[ad[AW-1:0] + AW'(k)] = {nv[4*(nn-1-2*k) +: 4], nv[4*(nn-2-2*k) +: 4]};
   endtask
   task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk_i);
      bd_we    = 1'b1;
      bd_addr  = a;
      bd_wdata = d;
      @(negedge clk_i);
      bd_we = 1'b0;
      ref_mem[a] = d;
   endtask
   task automatic bd_chk(input logic [AW-1:0] a, input string tag);
      @(negedge clk_i);
      bd_addr = a;
      @(negedge clk_i);
      chk(tag, 32'(bd_rdata), 32'(ref_mem[a]));
   endtask
   initial begin
      logic [3:0]  q, oe;
      logic [23:0] ad;
      logic [63:0] nv;
      int          nb;
      repeat (5) @(negedge clk_i);
      chk("rst sio_oe", 32'(sio_oe), 0);
      chk("rst sio_o", 32'(sio_o), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst cmd_err", 32'(cmd_err), 0);
      chk("rst bd_rdata", 32'(bd_rdata), 0);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      bd_write(12'h010, 8'h11);
      bd_write(12'h011, 8'h22);
      bd_write(12'h012, 8'h33);
      bd_write(12'h013, 8'h44);
      bd_chk(12'h012, "bd rd 012");
      qread(24'h000010, 4, "rd010");
      qwrite(24'h000020, 64'hABCD, 4, "wr020");
      bd_chk(12'h020, "bd 020");
      bd_chk(12'h021, "bd 021");
      qread(24'h000020, 2, "rd020");
      qwrite(24'h000FFF, 64'h5AA5, 4, "wrFFF");
      bd_chk(12'hFFF, "bd FFF");
      bd_chk(12'h000, "bd 000");
      qread(24'h123FFF, 2, "rd alias");
      err_pulses = 0;
      begin_txn();
      for (int i = 0; i < 8; i++) begin
         cyc({3'b000, 8'h9F >> (7 - i)} & 4'h1, q, oe);
         chk("9F cmd oe", 32'(oe), 0);
      end
      for (int i = 0; i < 20; i++) begin
         cyc(4'($urandom), q, oe);
         chk("9F ignore oe", 32'(oe), 0);
      end
      end_txn();
      chk("9F err pulses", 32'(err_pulses), 1);
      for (int i = 0; i < 4; i++) bd_chk(AW'(12'h010 + i), "9F mem");
      qread(24'h000010, 4, "rd after 9F");
      chk("err pulses total", 32'(err_pulses), 1);
      bd_write(12'h040, 8'h00);
      bd_write(12'h041, 8'h66);
      qwrite(24'h000040, 64'h789, 3, "wr abort");
      chk("abort busy", 32'(busy), 0);
      bd_chk(12'h040, "abort 040");
      bd_chk(12'h041, "abort 041");
      qread(24'h000040, 2, "rd abort");
      begin_txn();
      send_hdr(8'hEB, 24'h000010, "rst rd");
      for (int i = 0; i < DC; i++) cyc(4'h0, q, oe);
      cyc(4'h0, q, oe);
      chk("rst rd hi", 32'(q), 1);
      cyc(4'h0, q, oe);
      chk("rst rd lo", 32'(q), 1);
      chk("rst rd oe", 32'(oe), 32'hF);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("mid rst oe", 32'(sio_oe), 0);
      chk("mid rst busy", 32'(busy), 0);
      ce_n_i = 1'b1;
      sck_i  = 1'b0;
      repeat (4) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (4) @(negedge clk_i);
      qread(24'h000010, 4, "rd after rst");
      for (int r = 0; r < 6; r++) begin
         ad = 24'($urandom);
         nb = $urandom_range(1, 8);
         nv = {$urandom, $urandom};
         qwrite(ad, nv, 2 * nb, "rand wr");
         qread({8'($urandom), 4'($urandom), ad[AW-1:0]}, nb, "rand rd");
         bd_chk(ad[AW-1:0], "rand bd");
      end
      for (int r = 0; r < 3; r++) begin
         ad = 24'($urandom);
         bd_write(ad[AW-1:0], 8'($urandom));
         bd_write(ad[AW-1:0] + 1'b1, 8'($urandom));
         qread(ad, 2, "rand bd rd");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
